axi_ar_arbiter: RTL and testbench

Two-master round-robin arbiter for the AXI read-address (AR) channel, sitting in front of the read-address decoder inside the bus interconnect. It selects one master's AR request and forwards it to the slave side with the master index prepended to ARID. It holds the grant until the AR handshake completes. It also caps outstanding reads per master using R-channel completion pulses from the read-data path.

---
 rtl/axi_ar_arbiter.sv | 128 ++++++++++++
 tb/tb_axi_ar_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_arbiter.sv
// Two-master round-robin arbiter for the AXI AR channel, with per-master outstanding-read caps.
// Latency: the grant is registered, so ARVALID_S rises one cycle after an eligible request; ARREADY_S to ARREADY_Mx is combinational.
// Backpressure: a granted master is held until its AR handshake completes; a master at its cap is not granted until RDONE frees a slot.
module axi_ar_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_OUTS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   ARID_M0,
  input  logic [ADDR_WIDTH-1:0] ARADDR_M0,
  input  logic [3:0]            ARLEN_M0,
  input  logic [2:0]            ARSIZE_M0,
  input  logic [1:0]            ARBURST_M0,
  input  logic                  ARVALID_M0,
  output logic                  ARREADY_M0,
  input  logic                  RDONE_M0,
  input  logic [ID_WIDTH-1:0]   ARID_M1,
  input  logic [ADDR_WIDTH-1:0] ARADDR_M1,
  input  logic [3:0]            ARLEN_M1,
  input  logic [2:0]            ARSIZE_M1,
  input  logic [1:0]            ARBURST_M1,
  input  logic                  ARVALID_M1,
  output logic                  ARREADY_M1,
  input  logic                  RDONE_M1,
  output logic [ID_WIDTH:0]     ARID_S,
  output logic [ADDR_WIDTH-1:0] ARADDR_S,
  output logic [3:0]            ARLEN_S,
  output logic [2:0]            ARSIZE_S,
  output logic [1:0]            ARBURST_S,
  output logic                  ARVALID_S,
  input  logic                  ARREADY_S
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_t;

  localparam logic [3:0] OUTS_CAP = 4'(MAX_OUTS);

  state_t     state, state_nxt;
  logic       prio;
  logic [3:0] outs0, outs1;
  ar_t        req0, req1, sel;
  logic       gnt_idx;
  logic       elig0, elig1;
  logic       hs0, hs1;

  assign req0 = {ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0};
  assign req1 = {ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1};

  // Eligibility uses the counters as registered before this edge.
  assign elig0 = ARVALID_M0 && (outs0 < OUTS_CAP);
  assign elig1 = ARVALID_M1 && (outs1 < OUTS_CAP);

  assign hs0 = (state == GNT0) && ARVALID_M0 && ARREADY_S;
  assign hs1 = (state == GNT1) && ARVALID_M1 && ARREADY_S;

  always_comb begin
    state_nxt  = state;
    sel        = '0;
    gnt_idx    = 1'b0;
    ARVALID_S  = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 && elig1) state_nxt = prio ? GNT1 : GNT0;
        else if (elig0)     state_nxt = GNT0;
        else if (elig1)     state_nxt = GNT1;
      end
      GNT0: begin
        sel        = req0;
        ARVALID_S  = ARVALID_M0;
        ARREADY_M0 = ARREADY_S;
        if (hs0) state_nxt = IDLE;
      end
      GNT1: begin
        sel        = req1;
        gnt_idx    = 1'b1;
        ARVALID_S  = ARVALID_M1;
        ARREADY_M1 = ARREADY_S;
        if (hs1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ARID_S    = {gnt_idx, sel.id};
  assign ARADDR_S  = sel.addr;
  assign ARLEN_S   = sel.len;
  assign ARSIZE_S  = sel.size;
  assign ARBURST_S = sel.burst;

  // A completion arriving with nothing outstanding is dropped, so it never cancels an issue.
  function automatic logic [3:0] outs_upd(input logic [3:0] cur, input logic inc, input logic done);
    logic dec;
    dec = done && (cur != 4'd0);
    case ({inc, dec})
      2'b10:   outs_upd = cur + 4'd1;
      2'b01:   outs_upd = cur - 4'd1;
      default: outs_upd = cur;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      outs0 <= 4'd0;
      outs1 <= 4'd0;
    end else begin
      state <= state_nxt;
      if (hs0)      prio <= 1'b1;
      else if (hs1) prio <= 1'b0;
      outs0 <= outs_upd(outs0, hs0, RDONE_M0);
      outs1 <= outs_upd(outs1, hs1, RDONE_M1);
    end
  end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Bench for axi_ar_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_axi_ar_arbiter;

  localparam int IDW  = 4;
  localparam int AW   = 32;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [IDW-1:0] id_m[2];
  logic [AW-1:0]  addr_m[2];
  logic [3:0]     len_m[2];
  logic [2:0]     size_m[2];
  logic [1:0]     burst_m[2];
  logic           vld_m[2];
  logic           rdone_m[2];
  logic           rdy0, rdy1;

  logic [IDW:0]   arid_s;
  logic [AW-1:0]  araddr_s;
  logic [3:0]     arlen_s;
  logic [2:0]     arsize_s;
  logic [1:0]     arburst_s;
  logic           arvalid_s;
  logic           arready_s;

  int  total = 0;
  int  bad   = 0;
  bit  chk_en = 1'b0;

  // Model state: granted master (-1 = none), favoured master, outstanding counts, handshake seen at last edge.
  int  mg = -1;
  bit  mprio;
  int  mouts[2];
  bit  mhs[2];

  axi_ar_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .MAX_OUTS(MAXO)) u_dut (
    .clk(clk), .rst(rst),
    .ARID_M0(id_m[0]), .ARADDR_M0(addr_m[0]), .ARLEN_M0(len_m[0]), .ARSIZE_M0(size_m[0]),
    .ARBURST_M0(burst_m[0]), .ARVALID_M0(vld_m[0]), .ARREADY_M0(rdy0), .RDONE_M0(rdone_m[0]),
    .ARID_M1(id_m[1]), .ARADDR_M1(addr_m[1]), .ARLEN_M1(len_m[1]), .ARSIZE_M1(size_m[1]),
    .ARBURST_M1(burst_m[1]), .ARVALID_M1(vld_m[1]), .ARREADY_M1(rdy1), .RDONE_M1(rdone_m[1]),
    .ARID_S(arid_s), .ARADDR_S(araddr_s), .ARLEN_S(arlen_s), .ARSIZE_S(arsize_s),
    .ARBURST_S(arburst_s), .ARVALID_S(arvalid_s), .ARREADY_S(arready_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    bit p, hs;
    int o[2];
    bit h[2];
    bit el[2];
    g = mg; p = mprio; o[0] = mouts[0]; o[1] = mouts[1];
    h[0] = 1'b0; h[1] = 1'b0; hs = 1'b0;
    if (!rst) begin
      g = -1; p = 1'b0; o[0] = 0; o[1] = 0;
    end else begin
      if (g >= 0) hs = vld_m[g] && arready_s;
      for (int m = 0; m < 2; m++) begin
        el[m] = vld_m[m] && (o[m] < MAXO);
        h[m]  = hs && (g == m);
        if (h[m]) o[m] = o[m] + 1;
        if (rdone_m[m] && mouts[m] > 0) o[m] = o[m] - 1;
      end
      if (g < 0) begin
        if (el[0] && el[1]) g = p ? 1 : 0;
        else if (el[0])     g = 0;
        else if (el[1])     g = 1;
      end else if (hs) begin
        p = (g == 0);
        g = -1;
      end
    end
    mg <= g; mprio <= p; mouts[0] <= o[0]; mouts[1] <= o[1];
    mhs[0] <= h[0]; mhs[1] <= h[1];
  endtask

  always @(posedge clk) model_step();

  task automatic compare_all();
    logic ev, er0, er1;
    logic [IDW:0] eid;
    logic [AW-1:0] ea;
    logic [3:0] el;
    logic [2:0] es;
    logic [1:0] eb;
    ev = 1'b0; er0 = 1'b0; er1 = 1'b0; eid = '0; ea = '0; el = '0; es = '0; eb = '0;
    if (mg >= 0) begin
      ev  = vld_m[mg];
      eid = {mg[0], id_m[mg]};
      ea  = addr_m[mg];
      el  = len_m[mg];
      es  = size_m[mg];
      eb  = burst_m[mg];
      er0 = (mg == 0) && arready_s;
      er1 = (mg == 1) && arready_s;
    end
    chk("arvalid_s", 64'(arvalid_s), 64'(ev));
    chk("arid_s",    64'(arid_s),    64'(eid));
    chk("araddr_s",  64'(araddr_s),  64'(ea));
    chk("arlen_s",   64'(arlen_s),   64'(el));
    chk("arsize_s",  64'(arsize_s),  64'(es));
    chk("arburst_s", 64'(arburst_s), 64'(eb));
    chk("arready_m0", 64'(rdy0), 64'(er0));
    chk("arready_m1", 64'(rdy1), 64'(er1));
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) compare_all();
  end

  task automatic clr_in();
    for (int m = 0; m < 2; m++) begin
      id_m[m] = '0; addr_m[m] = '0; len_m[m] = '0; size_m[m] = '0; burst_m[m] = '0;
      vld_m[m] = 1'b0; rdone_m[m] = 1'b0;
    end
    arready_s = 1'b0;
  endtask

  // Leaves the caller at a negedge with reset released and all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clr_in();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic t_single();
    do_reset();
    vld_m[0] = 1'b1; id_m[0] = 4'h3; addr_m[0] = 32'h1000; len_m[0] = 4'h7; size_m[0] = 3'd2;
    burst_m[0] = 2'd1; arready_s = 1'b1;
    #3 chk("single_c0_vld", 64'(arvalid_s), 64'd0);
    @(negedge clk); #3;
    chk("single_vld",  64'(arvalid_s), 64'd1);
    chk("single_arid", 64'(arid_s),    64'h03);
    chk("single_addr", 64'(araddr_s),  64'h1000);
    chk("single_rdy0", 64'(rdy0),      64'd1);
    @(negedge clk);
    vld_m[0] = 1'b0;
    #3;
    chk("single_outs_model", 64'(mouts[0]), 64'd1);
    chk("single_outs_dut",   64'(u_dut.outs0), 64'd1);
  endtask

  task automatic t_contention();
    int msb_q[$];
    int cyc_q[$];
    do_reset();
    vld_m[0] = 1'b1; id_m[0] = 4'h1; addr_m[0] = 32'h100;
    vld_m[1] = 1'b1; id_m[1] = 4'h2; addr_m[1] = 32'h200;
    arready_s = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #3;
      if (arvalid_s && arready_s) begin
        msb_q.push_back(int'(arid_s[IDW]));
        cyc_q.push_back(c);
      end
      @(negedge clk);
    end
    vld_m[0] = 1'b0; vld_m[1] = 1'b0;
    chk("cont_count", 64'(msb_q.size()), 64'd4);
    for (int i = 0; i < msb_q.size(); i++) begin
      chk("cont_order", 64'(msb_q[i]), 64'(i % 2));
      chk("cont_cycle", 64'(cyc_q[i]), 64'(1 + 2 * i));
    end
  endtask

  task automatic t_backpressure();
    do_reset();
    vld_m[1] = 1'b1; id_m[1] = 4'h5; addr_m[1] = 32'hABCD0; len_m[1] = 4'h3;
    arready_s = 1'b0;
    @(negedge clk);
    vld_m[0] = 1'b1; id_m[0] = 4'h6; addr_m[0] = 32'h4444;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("bp_vld",  64'(arvalid_s), 64'd1);
      chk("bp_arid", 64'(arid_s),    64'h15);
      chk("bp_addr", 64'(araddr_s),  64'hABCD0);
      chk("bp_rdy1", 64'(rdy1),      64'd0);
      chk("bp_rdy0", 64'(rdy0),      64'd0);
      @(negedge clk);
    end
    arready_s = 1'b1;
    #3 chk("bp_hs_rdy1", 64'(rdy1 && arvalid_s), 64'd1);
    @(negedge clk);
    vld_m[1] = 1'b0;
    #3 chk("bp_idle", 64'(arvalid_s), 64'd0);
    @(negedge clk); #3;
    chk("bp_m0_next", 64'(arvalid_s && !arid_s[IDW]), 64'd1);
    @(negedge clk);
    vld_m[0] = 1'b0;
  endtask

  task automatic t_cap();
    int m1hs;
    m1hs = 0;
    do_reset();
    vld_m[0] = 1'b1; id_m[0] = 4'h7; addr_m[0] = 32'h7000; arready_s = 1'b1;
    for (int k = 0; k < 20 && mouts[0] < MAXO; k++) @(negedge clk);
    chk("cap_fill_model", 64'(mouts[0]), 64'd4);
    chk("cap_fill_dut",   64'(u_dut.outs0), 64'd4);
    vld_m[1] = 1'b1; id_m[1] = 4'h9; addr_m[1] = 32'h9000;
    for (int c = 0; c < 8; c++) begin
      #3;
      chk("cap_blk0", 64'(rdy0), 64'd0);
      if (arvalid_s) chk("cap_m1_only", 64'(arid_s[IDW]), 64'd1);
      if (arvalid_s && rdy1) m1hs++;
      @(negedge clk);
      if (m1hs >= 2) vld_m[1] = 1'b0;
    end
    chk("cap_m1_served", 64'(m1hs), 64'd2);
    rdone_m[0] = 1'b1;
    #3 chk("cap_rd_c0", 64'(arvalid_s), 64'd0);
    @(negedge clk);
    rdone_m[0] = 1'b0;
    #3 chk("cap_rd_c1", 64'(arvalid_s), 64'd0);
    @(negedge clk); #3;
    chk("cap_rd_c2", 64'(arvalid_s && !arid_s[IDW]), 64'd1);
    @(negedge clk);
    vld_m[0] = 1'b0;
  endtask

  task automatic t_incdec();
    do_reset();
    vld_m[0] = 1'b1; id_m[0] = 4'h2; arready_s = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        rdone_m[0] = 1'b1;
        rdone_m[1] = 1'b1;
      end
      #3;
      if (c == 5) chk("incdec_hs", 64'(rdy0 && arvalid_s), 64'd1);
      @(negedge clk);
    end
    rdone_m[0] = 1'b0; rdone_m[1] = 1'b0; vld_m[0] = 1'b0;
    #3;
    chk("incdec_model0", 64'(mouts[0]), 64'd2);
    chk("incdec_model1", 64'(mouts[1]), 64'd0);
    chk("incdec_dut0",   64'(u_dut.outs0), 64'd2);
    chk("incdec_dut1",   64'(u_dut.outs1), 64'd0);
  endtask

  task automatic t_midreset();
    do_reset();
    vld_m[0] = 1'b1; id_m[0] = 4'hA; arready_s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vld_m[0] = 1'b0; vld_m[1] = 1'b1; id_m[1] = 4'hC; arready_s = 1'b0;
    @(negedge clk);
    vld_m[0] = 1'b1;
    #3 chk("mr_gnt1", 64'(arvalid_s && arid_s[IDW]), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk("mr_vld",  64'(arvalid_s), 64'd0);
    chk("mr_prio", 64'(u_dut.prio), 64'd0);
    chk("mr_outs0", 64'(u_dut.outs0), 64'd0);
    chk("mr_model_prio", 64'(mprio), 64'd0);
    @(negedge clk); #3;
    chk("mr_m0_first", 64'(arvalid_s && !arid_s[IDW]), 64'd1);
  endtask

  task automatic t_random();
    int hs_cnt;
    hs_cnt = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (mhs[m]) hs_cnt++;
        if (mhs[m] || !vld_m[m]) begin
          vld_m[m] = ($urandom_range(0, 2) == 0);
          id_m[m]    = IDW'($urandom);
          addr_m[m]  = $urandom;
          len_m[m]   = 4'($urandom);
          size_m[m]  = 3'($urandom);
          burst_m[m] = 2'($urandom);
        end
        rdone_m[m] = ($urandom_range(0, 3) == 0);
      end
      arready_s = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    chk("rand_progress", 64'(hs_cnt > 200), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    @(negedge clk);
    chk_en = 1'b1;
    #3;
    chk("reset_arvalid", 64'(arvalid_s), 64'd0);
    chk("reset_arid",    64'(arid_s),    64'd0);
    chk("reset_model_idle", 64'(mg + 1), 64'd0);
    t_single();
    t_contention();
    t_backpressure();
    t_cap();
    t_incdec();
    t_midreset();
    t_random();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
